// File: rtl/mtsp_sync_pkg.sv
// mtsp_sync_pkg: shared widths, ID width helper and per-barrier state record for the barrier synchronizer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mtsp_sync_pkg;

    localparam int MTSP_SYNC_MAX_CORES = 32;

    // Barrier ID width; a single barrier still gets a 1-bit ID field.
    function automatic int mtsp_id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [MTSP_SYNC_MAX_CORES-1:0] mask;
        logic [MTSP_SYNC_MAX_CORES-1:0] arrived;
        logic                           done;
    } barrier_state_t;

endpackage

// File: rtl/mtsp_barrier_slot.sv
// mtsp_barrier_slot: one barrier's participation mask, arrival vector, completion pulse and optional hang timer.
// Latency: completing arrival in cycle N -> done high in N+1, arrived cleared in N+2.
// Backpressure: none. Hang timer present only with MTSP_BARRIER_TIMEOUT_EN defined.
module mtsp_barrier_slot
    import mtsp_sync_pkg::*;
#(
    parameter int CORE_SIZE       = 4,
    parameter bit RESET_FULL_MASK = 1'b0,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cfg_wr,
    input  logic [CORE_SIZE-1:0] cfg_mask,
    input  logic [CORE_SIZE-1:0] arrive,
    output logic [CORE_SIZE-1:0] arrived,
    output logic                 done,
    output logic                 pending,
    output logic                 timeout_err
);

    localparam int MC = MTSP_SYNC_MAX_CORES;
    localparam logic [MC-1:0] RESET_MASK = RESET_FULL_MASK ? MC'({CORE_SIZE{1'b1}}) : MC'(0);

    barrier_state_t  st_q;
    barrier_state_t  st_d;
    logic [MC-1:0]   arrive_ext;

    // Arrivals during the release cycle land in the cleared vector and count toward the next round.
    always_comb begin
        arrive_ext   = MC'(arrive) & st_q.mask;
        st_d         = st_q;
        st_d.arrived = (st_q.done ? MC'(0) : st_q.arrived) | arrive_ext;
        st_d.done    = (st_q.mask != MC'(0)) &&
                       ((st_d.arrived & st_q.mask) == st_q.mask) &&
                       !st_q.done;
        if (cfg_wr) begin
            st_d.mask    = MC'(cfg_mask);
            st_d.arrived = MC'(0);
            st_d.done    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q.mask    <= RESET_MASK;
            st_q.arrived <= MC'(0);
            st_q.done    <= 1'b0;
        end else begin
            st_q <= st_d;
        end
    end

    assign arrived = st_q.arrived[CORE_SIZE-1:0];
    assign done    = st_q.done;
    assign pending = |st_q.arrived;

`ifdef MTSP_BARRIER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Count holds at TIMEOUT_CYCLES; flag lands the cycle the count reaches it.
    always_ff @(posedge CLK) begin
        if (RST || cfg_wr) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (!pending) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (pending && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: rtl/mtsp_barrier_sync.sv
// mtsp_barrier_sync: BARRIER_COUNT maskable barriers; releases a one-cycle sync_ack to every participant on completion.
// Latency: last arriving sync_en rising edge in cycle N -> sync_ack in N+2.
// Backpressure: none; cores hold sync_en until ack. Hang timeout built only with MTSP_BARRIER_TIMEOUT_EN.
module mtsp_barrier_sync
    import mtsp_sync_pkg::*;
#(
    parameter int  CORE_SIZE      = 4,
    parameter int  BARRIER_COUNT  = 4,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int ID_W           = mtsp_id_width(BARRIER_COUNT)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CORE_SIZE-1:0]      sync_en,
    input  logic [CORE_SIZE*ID_W-1:0] sync_id,
    output logic [CORE_SIZE-1:0]      sync_ack,
    input  logic                      cfg_we,
    input  logic [ID_W-1:0]           cfg_id,
    input  logic [CORE_SIZE-1:0]      cfg_mask,
    output logic [BARRIER_COUNT-1:0]  pending,
    output logic [BARRIER_COUNT-1:0]  timeout_err
);

    logic [CORE_SIZE-1:0]     en_q;
    logic [CORE_SIZE-1:0]     rise;
    logic [CORE_SIZE-1:0]     ack_d;
    logic [CORE_SIZE-1:0]     arrived_vec [BARRIER_COUNT];
    logic [BARRIER_COUNT-1:0] done_vec;

    assign rise = sync_en & ~en_q;

    // IDs at or above BARRIER_COUNT match no slot and are dropped here.
    for (genvar b = 0; b < BARRIER_COUNT; b++) begin : g_bar
        logic [CORE_SIZE-1:0] arrive_b;

        always_comb begin
            arrive_b = '0;
            for (int c = 0; c < CORE_SIZE; c++) begin
                arrive_b[c] = rise[c] && (sync_id[c*ID_W +: ID_W] == ID_W'(b));
            end
        end

        mtsp_barrier_slot #(
            .CORE_SIZE       (CORE_SIZE),
            .RESET_FULL_MASK (b == 0),
            .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
        ) u_slot (
            .CLK         (CLK),
            .RST         (RST),
            .cfg_wr      (cfg_we && (cfg_id == ID_W'(b))),
            .cfg_mask    (cfg_mask),
            .arrive      (arrive_b),
            .arrived     (arrived_vec[b]),
            .done        (done_vec[b]),
            .pending     (pending[b]),
            .timeout_err (timeout_err[b])
        );
    end

    always_comb begin
        ack_d = '0;
        for (int b = 0; b < BARRIER_COUNT; b++) begin
            if (done_vec[b]) begin
                ack_d = ack_d | arrived_vec[b];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            en_q     <= '0;
            sync_ack <= '0;
        end else begin
            en_q     <= sync_en;
            sync_ack <= ack_d;
        end
    end

endmodule

// File: tb/tb_mtsp_barrier_sync.sv
// Directed bench for mtsp_barrier_sync: one table row per clock cycle with hand-computed ack/pending/timeout values.
// Timeout expectations follow MTSP_BARRIER_TIMEOUT_EN (TIMEOUT_CYCLES = 8 here).
module tb_mtsp_barrier_sync;

`ifdef MTSP_BARRIER_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] sync_en;
    logic [7:0] sync_id;
    logic [3:0] sync_ack;
    logic       cfg_we;
    logic [1:0] cfg_id;
    logic [3:0] cfg_mask;
    logic [3:0] pending;
    logic [3:0] timeout_err;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] en;
        logic [7:0] ids;
        logic       we;
        logic [1:0] cid;
        logic [3:0] cmask;
        logic [3:0] ack;
        logic [3:0] pend;
        logic [3:0] terr;
    } vec_t;

    vec_t vq[$];

    mtsp_barrier_sync #(
        .CORE_SIZE      (4),
        .BARRIER_COUNT  (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .sync_en     (sync_en),
        .sync_id     (sync_id),
        .sync_ack    (sync_ack),
        .cfg_we      (cfg_we),
        .cfg_id      (cfg_id),
        .cfg_mask    (cfg_mask),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic [3:0] en, input logic [7:0] ids, input logic we,
                                input logic [1:0] cid, input logic [3:0] cm, input logic [3:0] ack,
                                input logic [3:0] pend, input logic [3:0] terr);
        vec_t v;
        v.en = en; v.ids = ids; v.we = we; v.cid = cid; v.cmask = cm;
        v.ack = ack; v.pend = pend; v.terr = terr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Entered just after a rising edge: drive, check on the falling edge, advance one cycle.
    task automatic run(input vec_t v, input string tag);
        sync_en  = v.en;
        sync_id  = v.ids;
        cfg_we   = v.we;
        cfg_id   = v.cid;
        cfg_mask = v.cmask;
        @(negedge CLK);
        chk({tag, ".ack"}, sync_ack, v.ack);
        chk({tag, ".pending"}, pending, v.pend);
        chk({tag, ".timeout"}, timeout_err, v.terr);
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RST     = 1'b1;
        sync_en = 4'b0000;
        cfg_we  = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        logic [3:0] te;
        RST = 1'b1; sync_en = '0; sync_id = '0; cfg_we = 1'b0; cfg_id = '0; cfg_mask = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset-default barrier 0: arrivals in cycles 3,5,6,9 -> ack in 11, pending 4..10.
        vq.push_back(mk(4'b0000, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0001, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0001, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, 0));
        vq.push_back(mk(4'b0011, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, 0));
        vq.push_back(mk(4'b0111, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, 0));
        vq.push_back(mk(4'b0111, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, 0));
        vq.push_back(mk(4'b0111, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, 0));
        vq.push_back(mk(4'b1111, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, 0));
        vq.push_back(mk(4'b1111, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, 0));
        vq.push_back(mk(4'b1111, 8'h00, 0, 0, 0, 4'b1111, 4'b0000, 0));
        vq.push_back(mk(4'b1111, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, 0));
        // Barrier 1 mask 0101; then core 1 (outside mask) is ignored.
        vq.push_back(mk(4'b0000, 8'h00, 1, 1, 4'b0101, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0101, 8'h55, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0101, 8'h55, 0, 0, 0, 4'b0000, 4'b0010, 0));
        vq.push_back(mk(4'b0101, 8'h55, 0, 0, 0, 4'b0101, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 8'h55, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0010, 8'h55, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0010, 8'h55, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0010, 8'h55, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 8'h55, 0, 0, 0, 4'b0000, 4'b0000, 0));
        // Barrier 3 still has a zero mask: arrival ignored.
        vq.push_back(mk(4'b0001, 8'h03, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0001, 8'h03, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 8'h03, 0, 0, 0, 4'b0000, 4'b0000, 0));
        // Concurrent barriers 1 (0011) and 2 (1100) completing together; core 0 then holds en.
        vq.push_back(mk(4'b0000, 8'h00, 1, 1, 4'b0011, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 8'h00, 1, 2, 4'b1100, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0001, 8'hA5, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0101, 8'hA5, 0, 0, 0, 4'b0000, 4'b0010, 0));
        vq.push_back(mk(4'b1111, 8'hA5, 0, 0, 0, 4'b0000, 4'b0110, 0));
        vq.push_back(mk(4'b1111, 8'hA5, 0, 0, 0, 4'b0000, 4'b0110, 0));
        vq.push_back(mk(4'b1111, 8'hA5, 0, 0, 0, 4'b1111, 4'b0000, 0));
        vq.push_back(mk(4'b0001, 8'hA5, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0001, 8'hA5, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0001, 8'hA5, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 8'hA5, 0, 0, 0, 4'b0000, 4'b0000, 0));
        // Single-core barrier 3: one ack two cycles after each rising edge.
        vq.push_back(mk(4'b0000, 8'h03, 1, 3, 4'b0001, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0001, 8'h03, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0001, 8'h03, 0, 0, 0, 4'b0000, 4'b1000, 0));
        vq.push_back(mk(4'b0000, 8'h03, 0, 0, 0, 4'b0001, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 8'h03, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0001, 8'h03, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0001, 8'h03, 0, 0, 0, 4'b0000, 4'b1000, 0));
        vq.push_back(mk(4'b0000, 8'h03, 0, 0, 0, 4'b0001, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 8'h03, 0, 0, 0, 4'b0000, 4'b0000, 0));
        // Abort: cores 0,1 pending on barrier 1 (0111), cfg write with core 2 arriving same cycle.
        vq.push_back(mk(4'b0000, 8'h15, 1, 1, 4'b0111, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0011, 8'h15, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0011, 8'h15, 0, 0, 0, 4'b0000, 4'b0010, 0));
        vq.push_back(mk(4'b0111, 8'h15, 1, 1, 4'b0111, 4'b0000, 4'b0010, 0));
        vq.push_back(mk(4'b0111, 8'h15, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0111, 8'h15, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 8'h15, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0111, 8'h15, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vq.push_back(mk(4'b0111, 8'h15, 0, 0, 0, 4'b0000, 4'b0010, 0));
        vq.push_back(mk(4'b0111, 8'h15, 0, 0, 0, 4'b0111, 4'b0000, 0));
        vq.push_back(mk(4'b0000, 8'h15, 0, 0, 0, 4'b0000, 4'b0000, 0));

        for (int i = 0; i < vq.size(); i++) begin
            run(vq[i], $sformatf("vec%0d", i));
        end

        // Reset mid-barrier: cores 0,1 arrivals are lost, so cores 2,3 alone cannot complete.
        run(mk(4'b0011, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, 0), "rst.arr0");
        run(mk(4'b0011, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, 0), "rst.arr1");
        pulse_reset();
        run(mk(4'b0000, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, 0), "rst.clear");
        run(mk(4'b1100, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, 0), "rst.late0");
        run(mk(4'b1100, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, 0), "rst.late1");
        run(mk(4'b1100, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, 0), "rst.late2");
        run(mk(4'b1111, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, 0), "rst.rereq0");
        run(mk(4'b1111, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, 0), "rst.rereq1");
        run(mk(4'b1111, 8'h00, 0, 0, 0, 4'b1111, 4'b0000, 0), "rst.ack");
        run(mk(4'b0000, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, 0), "rst.idle");

        // Long pending on barrier 0: flag 8 cycles after pending rises, barrier still completes.
        pulse_reset();
        run(mk(4'b0001, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, 0), "to.arrive");
        for (int k = 1; k <= 10; k++) begin
            te = (TO_ON && (k >= 9)) ? 4'b0001 : 4'b0000;
            run(mk(4'b0001, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, te), $sformatf("to.wait%0d", k));
        end
        te = TO_ON ? 4'b0001 : 4'b0000;
        run(mk(4'b1111, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, te), "to.rest0");
        run(mk(4'b1111, 8'h00, 0, 0, 0, 4'b0000, 4'b0001, te), "to.rest1");
        run(mk(4'b1111, 8'h00, 0, 0, 0, 4'b1111, 4'b0000, te), "to.ack");
        run(mk(4'b0000, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, te), "to.sticky");
        run(mk(4'b0000, 8'h00, 1, 0, 4'b1111, 4'b0000, 4'b0000, te), "to.cfg");
        run(mk(4'b0000, 8'h00, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000), "to.cleared");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mtsp_barrier_sync.md
# mtsp_barrier_sync

Multi-barrier synchronizer for the MTSP multi-core cluster: each core raises a sync request tagged with a barrier ID, and the block releases a one-cycle acknowledge to every participating core once all cores in that barrier's programmable participation mask have arrived. It replaces the single all-core barrier with BARRIER_COUNT independent, maskable barriers and an optional hang-detection timeout. It sits between the per-core sync ports and the system register bus.

## Interface
- CORE_SIZE, 4: number of cores, 1..32
- BARRIER_COUNT, 4: independent barriers, 1..16; ID_W = max(1, $clog2(BARRIER_COUNT))
- TIMEOUT_CYCLES, 1024: cycles from first arrival to timeout flag, ≥2; only used with the timeout macro
- CLK  in  1  system clock; one clock, all logic on rising edge
- RST  in  1  reset; reset is synchronous and active-high
- sync_en  in  CORE_SIZE  per-core request level; held high until ack is seen
- sync_id  in  CORE_SIZE×ID_W  per-core barrier ID; core c uses slice [c×ID_W +: ID_W]; valid while sync_en[c]
- sync_ack  out  CORE_SIZE  one-cycle release pulse per core
- cfg_we  in  1  write participation mask
- cfg_id  in  ID_W  barrier selected by cfg_we
- cfg_mask  in  CORE_SIZE  new participation mask
- pending  out  BARRIER_COUNT  barrier has ≥1 arrived core
- timeout_err  out  BARRIER_COUNT  sticky timeout flag per barrier

## Operation
- Per barrier b: mask[b], arrived[b] (CORE_SIZE bits), done_q[b]. Per core: en_q (previous sync_en).
- Arrival of core c at b: sync_en[c] & ~en_q[c] (rising edge only) & sync_id[c]==b & mask[b][c]. Held-high en never re-arrives. A rising edge from a core outside mask[b] is ignored.
- sync_id ≥ BARRIER_COUNT: request ignored.
- complete[b] = (mask[b]!=0) & ((arrived[b] & mask[b]) == mask[b]) & ~done_q[b]; registered into done_q[b].
- While done_q[b] is high: arrived[b] clears to 0 and new arrivals that cycle are merged into the cleared vector, so they count toward the next round. done_q[b] self-clears after one cycle.
- sync_ack[c] = registered OR over b of (done_q[b] & arrived[b][c]).
- Multiple barriers may complete in the same cycle. Each releases its own cores.
- mask[b] == 0: the barrier never completes and arrivals are ignored.
- cfg_we: mask[cfg_id] ← cfg_mask, arrived[cfg_id] ← 0, done_q[cfg_id] ← 0, timeout_err[cfg_id] ← 0. Pending cores are dropped without ack.
- cfg_we takes priority over arrival and completion for the same barrier in the same cycle.
- pending[b] = |arrived[b].

## Timing
- Reset values:
  - mask[0] = all ones; mask[1..] = 0
  - arrived, done_q, en_q, sync_ack, timeout_err = 0
  - pending = 0
- Last arriver's rising edge sampled in cycle N:
  - arrived bit visible in N+1
  - done_q high in N+1
  - sync_ack high in N+2 for exactly one cycle
  - arrived cleared (pending low) in N+2
- Single-core mask: en rising in N → ack in N+2.
- Minimum re-sync period per core: drop en at least 1 cycle, then re-raise.
- RST mid-barrier: all arrivals are lost and no ack is issued. Cores must re-request.

## Configuration
- MTSP_BARRIER_TIMEOUT_EN defined: each barrier has a counter of width $clog2(TIMEOUT_CYCLES+1).
  - Counter clears while pending[b] is low and increments while it is high.
  - When the count reaches TIMEOUT_CYCLES, timeout_err[b] sets (sticky).
  - The barrier stays armed; a later completion still acks normally.
  - timeout_err[b] clears only on cfg_we to b or on RST.
- Macro undefined: no counters; timeout_err is tied to 0.

## Structure
- Package mtsp_sync_pkg: ID_W function/localparam, barrier state typedef (mask, arrived, done), MTSP_SYNC_MAX_CORES = 32.
- Sub-module mtsp_barrier_slot: one barrier's mask/arrived/done/timeout logic. Instantiated BARRIER_COUNT times in a generate loop.
- Top level: en_q edge detection, ID decode, ack OR-reduction/register.

## Test plan
- Reset default: 4 cores raise en with id 0 in cycles 3,5,6,9 → sync_ack=4'b1111 only in cycle 11; pending[0] high cycles 4–10.
- Masked barrier: mask[1]=4'b0101 written; cores 0,2 request id 1 at cycle 10 → ack 4'b0101 in cycle 12. Core 1 requesting id 1 → no effect.
- Concurrent barriers: mask[1]=0011, mask[2]=1100, all four complete in cycle 20 → ack 1111 in cycle 22. Core 0 holds en high through cycle 30 → no second ack.
- Re-arm: core 0 alone in mask[3] toggles en low/high every 2 cycles → one ack per rising edge, 2 cycles later.
- Abort: cores 0,1 pending on barrier 1; cfg_we to barrier 1 → pending[1]=0, no ack. Same-cycle arrival is discarded.
- Timeout (macro on, TIMEOUT_CYCLES=8): core 0 arrives at barrier 0, cores 1–3 never arrive → timeout_err[0] set 8 cycles after pending[0] rises. Later arrivals → ack still issued and timeout_err stays 1.
